// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam int unsigned KEY_W               = 4;
  localparam int unsigned VAL_W               = 16;
  localparam int unsigned REPEAT_DELAY_TICKS  = 512;
  localparam int unsigned REPEAT_PERIOD_TICKS = 128;
  localparam int unsigned REP_CNT_W           = 10;

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: control in, keypad matrix, key/entry outputs.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic             en;
  logic             clear;
  logic [3:0]       row;
  logic [3:0]       col;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic [VAL_W-1:0] val;

  modport master (output en, clear, row, input col, key_valid, key_code, val);
  modport slave  (input en, clear, row, output col, key_valid, key_code, val);
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// Scan prescaler: one-clock tick every TICK_DIV clocks, restartable.
module keypad_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == CNT_W'(TICK_DIV - 1));
  assign tick_c = at_end && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (restart || at_end) cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce and hex entry shift register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 100000000,
  parameter int unsigned SCAN_RATE_HZ   = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.slave  bus
);

  localparam int unsigned TICK_RAW = SYS_CLK_FREQ / SCAN_RATE_HZ;
  localparam int unsigned TICK_DIV = (TICK_RAW < 2) ? 2 : TICK_RAW;
  localparam int unsigned DB_W     = 4;

  logic             tick;
  logic [3:0]       row_s1, rs;
  logic             single;
  logic [1:0]       r_smp;

  state_e           state, state_n;
  logic [1:0]       c_idx, c_n, r_idx, r_n;
  logic [DB_W-1:0]  cnt, cnt_n;
  logic [3:0]       col_q, col_n;
  logic             kv_q, kv_n;
  logic [KEY_W-1:0] code_q, code_n;
  logic [VAL_W-1:0] val_q, val_n;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_CNT_W-1:0] rep_cnt, rep_n;
`endif

  keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (!bus.en),
    .tick_c  (tick)
  );

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_s1 <= bus.row;
      rs     <= row_s1;
    end
  end

  // Exactly one row low is a key; none or several (ghosting) is no key.
  always_comb begin
    single = 1'b1;
    r_smp  = 2'd0;
    case (rs)
      4'b1110: r_smp = 2'd0;
      4'b1101: r_smp = 2'd1;
      4'b1011: r_smp = 2'd2;
      4'b0111: r_smp = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      c_idx   <= '0;
      r_idx   <= '0;
      cnt     <= '0;
      col_q   <= 4'hF;
      kv_q    <= 1'b0;
      code_q  <= '0;
      val_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      c_idx   <= c_n;
      r_idx   <= r_n;
      cnt     <= cnt_n;
      col_q   <= col_n;
      kv_q    <= kv_n;
      code_q  <= code_n;
      val_q   <= val_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= rep_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    c_n     = c_idx;
    r_n     = r_idx;
    cnt_n   = cnt;
    kv_n    = 1'b0;
    code_n  = code_q;
    val_n   = val_q;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep_cnt;
`endif

    case (state)
      SCAN: begin
        if (tick) begin
          if (single) begin
            r_n     = r_smp;
            cnt_n   = DB_W'(1);
            state_n = (DEBOUNCE_SCANS <= 1) ? PRESSED : DEBOUNCE;
          end else begin
            c_n = c_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (single && (r_smp == r_idx)) begin
            cnt_n = cnt + DB_W'(1);
            if (cnt_n >= DB_W'(DEBOUNCE_SCANS)) state_n = PRESSED;
          end else begin
            state_n = SCAN;
            c_n     = c_idx + 2'd1;
            cnt_n   = '0;
          end
        end
      end
      PRESSED: begin
        state_n = RELEASE;
        cnt_n   = '0;
        val_n   = {val_q[VAL_W-KEY_W-1:0], code_q};
      end
      RELEASE: begin
        if (tick) begin
          if (rs[r_idx]) begin
            cnt_n = cnt + DB_W'(1);
`ifdef KEYPAD_REPEAT_EN
            rep_n = '0;
`endif
            if (cnt_n >= DB_W'(DEBOUNCE_SCANS)) begin
              state_n = SCAN;
              c_n     = c_idx + 2'd1;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
            // Rewind by one period after each emission so repeats follow the period.
            if (rep_cnt == REP_CNT_W'(REPEAT_DELAY_TICKS - 1)) begin
              state_n = PRESSED;
              rep_n   = REP_CNT_W'(REPEAT_DELAY_TICKS - REPEAT_PERIOD_TICKS);
            end else begin
              rep_n = rep_cnt + REP_CNT_W'(1);
            end
`endif
          end
        end
      end
      default: state_n = SCAN;
    endcase

    // Key pulse and code are registered on entry to PRESSED; val shifts on exit.
    if (state_n == PRESSED) begin
      kv_n   = 1'b1;
      code_n = KEY_W'({r_n, c_n});
    end

    if (!bus.en) begin
      state_n = SCAN;
      c_n     = '0;
      cnt_n   = '0;
      kv_n    = 1'b0;
      code_n  = code_q;
      val_n   = val_q;
`ifdef KEYPAD_REPEAT_EN
      rep_n   = '0;
`endif
    end

    if (bus.clear) val_n = '0;

    col_n = bus.en ? col_drive(c_n) : 4'hF;
  end

  assign bus.col       = col_q;
  assign bus.key_valid = kv_q;
  assign bus.key_code  = code_q;
  assign bus.val       = val_q;

endmodule
